spike_sample_player: RTL and testbench

//   Synthesizable, parametrised successor to the spike-sample file reader.

---
 rtl/spike_sample_player.sv | 176 +++++++++++++++++
 tb/tb_spike_sample_player.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_sample_player.sv
// Spike-sample player: on-chip sample RAM streamed
// to the SNN input layer under valid/ready.
module spike_sample_player #(
  parameter int W         = 42,
  parameter int DEPTH     = 9000,
  parameter int AW        = 14,
  parameter int HOLD      = 1,
  parameter     INIT_FILE = "sample_eT1.mem"
) (
  input  logic          i_clk,
  input  logic          r_rst_n,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_loop,
  input  logic [AW-1:0] i_len,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_ready,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_idx,
  output logic [15:0]   o_wraps
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DONE
  } state_t;

  logic [W-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] last_q, last_d;
  logic          loop_q, loop_d;
  logic [15:0]   wraps_q, wraps_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [W-1:0]  rd_q;

  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic          we;
  logic          xfer;
  logic          at_last;
  logic [AW-1:0] next_idx;
  logic [AW-1:0] len_last;

  assign xfer     = valid_q & i_ready;
  assign at_last  = (idx_q == last_q);
  assign next_idx = at_last ? '0 : idx_q + AW'(1);

  // Zero or oversize length selects the whole memory
  assign len_last =
    (i_len == '0 || {1'b0, i_len} > DEPTH_W)
      ? LAST_MAX : i_len - AW'(1);

  // Next-state, read-address and handshake logic
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    last_d  = last_q;
    loop_d  = loop_q;
    wraps_d = wraps_q;
    hcnt_d  = hcnt_q;
    rd_addr = idx_q;
    rd_en   = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        we = i_wr_en &
             ({1'b0, i_wr_addr} < DEPTH_W);
        if (i_start && !i_stop) begin
          last_d  = len_last;
          loop_d  = i_loop;
          wraps_d = '0;
          idx_d   = '0;
          rd_addr = '0;
          rd_en   = 1'b1;
          state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        rd_en   = 1'b1;
        valid_d = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        rd_en = 1'b1;
        if (xfer) begin
          idx_d   = next_idx;
          rd_addr = next_idx;
          if (HOLD > 1) begin
            valid_d = 1'b0;
            hcnt_d  = HW'(HOLD - 1);
          end
          if (at_last) begin
            if (loop_q) begin
              if (wraps_q != 16'hFFFF)
                wraps_d = wraps_q + 16'd1;
            end else begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end else if (!valid_q) begin
          hcnt_d = hcnt_q - HW'(1);
          if (hcnt_q == HW'(1))
            valid_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Stop aborts any playback; a sample
    // accepted this cycle still counts
    if (i_stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Sample RAM write port, open only in IDLE
  always_ff @(posedge i_clk) begin
    if (we) mem[i_wr_addr] <= i_wr_data;
  end

  // State, output and RAM read registers
  always_ff @(posedge i_clk) begin
    if (!r_rst_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      wraps_q <= '0;
      hcnt_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      wraps_q <= wraps_d;
      hcnt_q  <= hcnt_d;
      if (rd_en) rd_q <= mem[rd_addr];
    end
  end

  assign o_data  = rd_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done_q;
  assign o_idx   = idx_q;
  assign o_wraps = wraps_q;

endmodule

// File: tb/tb_spike_sample_player.sv
// Directed bench for spike_sample_player with a
// sample scoreboard and a HOLD=4 second instance.
module tb_spike_sample_player;

  localparam int W  = 42;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, loop_m;
  logic [AW-1:0] len;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          ready;

  logic [W-1:0]  o_data, h4_data;
  logic          o_valid, h4_valid;
  logic          o_busy, h4_busy;
  logic          o_done, h4_done;
  logic [AW-1:0] o_idx, h4_idx;
  logic [15:0]   o_wraps, h4_wraps;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  logic [W-1:0]  exp_d [$];
  logic [AW-1:0] exp_i [$];
  logic [W-1:0]  mdl [16];

  always #5 clk = ~clk;

  spike_sample_player #(
    .W(W), .DEPTH(9000), .AW(AW),
    .HOLD(1), .INIT_FILE("")
  ) u_dut (
    .i_clk(clk), .r_rst_n(rst_n),
    .i_start(start), .i_stop(stop),
    .i_loop(loop_m), .i_len(len),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_ready(ready),
    .o_data(o_data), .o_valid(o_valid),
    .o_busy(o_busy), .o_done(o_done),
    .o_idx(o_idx), .o_wraps(o_wraps)
  );

  spike_sample_player #(
    .W(W), .DEPTH(16), .AW(AW),
    .HOLD(4), .INIT_FILE("")
  ) u_h4 (
    .i_clk(clk), .r_rst_n(rst_n),
    .i_start(start), .i_stop(stop),
    .i_loop(loop_m), .i_len(len),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_ready(ready),
    .o_data(h4_data), .o_valid(h4_valid),
    .o_busy(h4_busy), .o_done(h4_done),
    .o_idx(h4_idx), .o_wraps(h4_wraps)
  );

  task automatic chk(string tag,
                     logic [63:0] obs,
                     logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int k);
    exp_d.push_back(mdl[k]);
    exp_i.push_back(AW'(k));
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(o_busy), 64'd0);
  endtask

  // Scoreboard: every accepted sample is popped
  always @(negedge clk) begin
    if (o_valid && ready) begin
      vectors++;
      assert (exp_d.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_extra: got idx %0d want none",
               o_idx);
      end
      if (exp_d.size() != 0) begin
        chk("sb_data", 64'(o_data),
            64'(exp_d.pop_front()));
        chk("sb_idx", 64'(o_idx),
            64'(exp_i.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (o_done) done_cnt++;
  end

  initial begin
    int pos [4];
    logic [W-1:0] dat [4];
    int n;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    loop_m = 1'b0; len = '0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; ready = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_done", 64'(o_done), 0);
    chk("rst_idx", 64'(o_idx), 0);
    chk("rst_wraps", 64'(o_wraps), 0);
    chk("rst_data", 64'(o_data), 0);
    step();
    rst_n = 1'b1;

    // Preload mem[k] = k
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1;
      wr_addr = AW'(k);
      wr_data = W'(k);
      mdl[k] = W'(k);
      step();
    end
    wr_en = 1'b0;

    // 1: len=4 one-shot, back-to-back
    done_cnt = 0;
    for (int k = 0; k < 4; k++) push(k);
    len = 4; loop_m = 1'b0; ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("t1_prime_valid", 64'(o_valid), 0);
    step();
    @(negedge clk);
    chk("t1_valid_c2", 64'(o_valid), 1);
    for (int j = 1; j < 4; j++) begin
      step();
      @(negedge clk);
      chk("t1_nobubble", 64'(o_valid), 1);
    end
    step();
    @(negedge clk);
    chk("t1_done", 64'(o_done), 1);
    wait_idle("t1_idle");
    chk("t1_done_cnt", 64'(done_cnt), 1);
    chk("t1_sb_empty", 64'(exp_d.size()), 0);

    // 2: backpressure on 2nd and 3rd cycles
    done_cnt = 0;
    for (int k = 0; k < 4; k++) push(k);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    ready = 1'b0;
    @(negedge clk);
    chk("t2_hold_v", 64'(o_valid), 1);
    chk("t2_hold_d", 64'(o_data), 1);
    step();
    @(negedge clk);
    chk("t2_hold_v2", 64'(o_valid), 1);
    chk("t2_hold_d2", 64'(o_data), 1);
    step();
    ready = 1'b1;
    wait_idle("t2_idle");
    chk("t2_done_cnt", 64'(done_cnt), 1);
    chk("t2_sb_empty", 64'(exp_d.size()), 0);

    // 3: len=3 loop, 10 transfers, then stop
    done_cnt = 0;
    for (int k = 0; k < 10; k++) push(k % 3);
    len = 3; loop_m = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int j = 0; j < 9; j++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    chk("t3_valid_off", 64'(o_valid), 0);
    chk("t3_busy_off", 64'(o_busy), 0);
    chk("t3_wraps", 64'(o_wraps), 3);
    chk("t3_no_done", 64'(done_cnt), 0);
    chk("t3_sb_empty", 64'(exp_d.size()), 0);

    // 4: HOLD=4 instance, len=2
    for (int k = 0; k < 2; k++) push(k);
    len = 2; loop_m = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (h4_valid && n < 4) begin
        pos[n] = c;
        dat[n] = h4_data;
        n++;
      end
    end
    chk("t4_pulses", 64'(n), 2);
    chk("t4_first", 64'(pos[0]), 1);
    chk("t4_spacing", 64'(pos[1] - pos[0]), 4);
    chk("t4_data1", 64'(dat[1]), 1);
    chk("t4_h4_busy", 64'(h4_busy), 0);
    chk("t4_sb_empty", 64'(exp_d.size()), 0);

    // 5: idle write lands, busy write ignored
    step();
    wr_en = 1'b1;
    wr_addr = 5;
    wr_data = 42'h2AA;
    mdl[5] = 42'h2AA;
    step();
    wr_en = 1'b0;
    for (int k = 0; k < 7; k++) push(k);
    len = 7;
    start = 1'b1;
    step();
    start = 1'b0;
    wr_en = 1'b1;
    wr_addr = 6;
    wr_data = 42'h155;
    step();
    wr_en = 1'b0;
    wait_idle("t5_idle");
    chk("t5_sb_empty", 64'(exp_d.size()), 0);

    // 6: reset mid-stream at idx 2
    for (int k = 0; k < 3; k++) push(k);
    len = 8;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_valid", 64'(o_valid), 0);
    chk("t6_busy", 64'(o_busy), 0);
    chk("t6_idx", 64'(o_idx), 0);
    chk("t6_data", 64'(o_data), 0);
    chk("t6_wraps", 64'(o_wraps), 0);
    chk("t6_sb_empty", 64'(exp_d.size()), 0);
    for (int k = 0; k < 4; k++) push(k);
    len = 4;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("t6_restart_idle");
    chk("t6_restart_sb", 64'(exp_d.size()), 0);

    // start and stop together: no playback
    step();
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    chk("t6_ss_busy", 64'(o_busy), 0);
    step();
    @(negedge clk);
    chk("t6_ss_busy2", 64'(o_busy), 0);
    chk("t6_ss_valid", 64'(o_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
